// File: rtl/dda_stepper.sv
// dda_stepper
// Walks the map grid with DDA for one ray per column. For each ray it reads one
// cell per step from a map BRAM read port. It then reports the column, the wall
// type, the hit side and the perpendicular wall distance to the column renderer.
//
// Ports
//   pixel_clk_in                  clock
//   rst_in                        synchronous, active-low reset
//   valid_ray_in                  ray fields valid, held until accepted
//   stepX_in / stepY_in           1 = step +1, 0 = step -1
//   sideDistX_in / sideDistY_in   Q8.8 initial side distances
//   deltaDistX_in / deltaDistY_in Q8.8 per-cell increments
//   posX_in / posY_in             Q8.8 position; integer part = start cell
//   hcount_in                     screen column of the ray
//   dda_data_ready_out            ready to accept a ray
//   map_addr_out                  map read address (mapY*MAP_SIZE + mapX)
//   map_data_in                   cell type at map_addr_out, MAP_LAT cycles later
//   ready_in                      downstream can take a result
//   valid_out                     result valid, held until ready_in
//   hcount_out / wallType_out / wallSide_out / perpWallDist_out   result fields
module dda_stepper #(
   parameter int unsigned MAP_SIZE  = 24,
   parameter int unsigned MAP_LAT   = 2,
   parameter int unsigned MAX_STEPS = 64,
   parameter int unsigned ADDR_W    = $clog2(MAP_SIZE * MAP_SIZE)
) (
   input  logic              pixel_clk_in,
   input  logic              rst_in,
   input  logic              valid_ray_in,
   input  logic              stepX_in,
   input  logic              stepY_in,
   input  logic [15:0]       sideDistX_in,
   input  logic [15:0]       sideDistY_in,
   input  logic [15:0]       deltaDistX_in,
   input  logic [15:0]       deltaDistY_in,
   input  logic [15:0]       posX_in,
   input  logic [15:0]       posY_in,
   input  logic [8:0]        hcount_in,
   output logic              dda_data_ready_out,
   output logic [ADDR_W-1:0] map_addr_out,
   input  logic [3:0]        map_data_in,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [8:0]        hcount_out,
   output logic [3:0]        wallType_out,
   output logic              wallSide_out,
   output logic [15:0]       perpWallDist_out
);

   localparam int unsigned LAT_W = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_STEPS + 1);
   localparam logic [7:0]  MAP_LIM = 8'(MAP_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_CHECK = 3'd2,
      S_STEP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Registers and their next values
   state_t             r_state,    w_state_nxt;
   logic               r_step_x,   w_step_x_nxt;
   logic               r_step_y,   w_step_y_nxt;
   logic [15:0]        r_sdx,      w_sdx_nxt;
   logic [15:0]        r_sdy,      w_sdy_nxt;
   logic [15:0]        r_ddx,      w_ddx_nxt;
   logic [15:0]        r_ddy,      w_ddy_nxt;
   logic [7:0]         r_map_x,    w_map_x_nxt;
   logic [7:0]         r_map_y,    w_map_y_nxt;
   logic [8:0]         r_hcount,   w_hcount_nxt;
   logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
   logic [LAT_W-1:0]   r_wait,     w_wait_nxt;
   logic [15:0]        r_perp,     w_perp_nxt;
   logic               r_side,     w_side_nxt;
   logic               r_ready,    w_ready_nxt;
   logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
   logic               r_valid,    w_valid_nxt;
   logic [8:0]         r_hc_o,     w_hc_o_nxt;
   logic [3:0]         r_wt_o,     w_wt_o_nxt;
   logic               r_side_o,   w_side_o_nxt;
   logic [15:0]        r_perp_o,   w_perp_o_nxt;

   // Step-phase helpers
   logic       w_take_x;
   logic [7:0] w_mx_step;
   logic [7:0] w_my_step;
   logic [7:0] w_nx;
   logic [7:0] w_ny;

   // Only the integer cell of the position is used
   logic w_unused;
   assign w_unused = ^{posX_in[7:0], posY_in[7:0]};

   // Row-major map address of a cell
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
      logic [31:0] a;
      a = 32'(y) * 32'(MAP_SIZE) + 32'(x);
      return ADDR_W'(a);
   endfunction

   // Unsigned 16-bit add clamped at all-ones
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Tie between side distances steps along X
   assign w_take_x  = (r_sdx <= r_sdy);
   assign w_mx_step = r_map_x + (r_step_x ? 8'd1 : 8'hFF);
   assign w_my_step = r_map_y + (r_step_y ? 8'd1 : 8'hFF);
   assign w_nx      = w_take_x ? w_mx_step : r_map_x;
   assign w_ny      = w_take_x ? r_map_y   : w_my_step;

   // State and datapath registers
   always_ff @(posedge pixel_clk_in) begin
      if (!rst_in) begin
         r_state  <= S_IDLE;
         r_step_x <= 1'b0;
         r_step_y <= 1'b0;
         r_sdx    <= '0;
         r_sdy    <= '0;
         r_ddx    <= '0;
         r_ddy    <= '0;
         r_map_x  <= '0;
         r_map_y  <= '0;
         r_hcount <= '0;
         r_cnt    <= '0;
         r_wait   <= '0;
         r_perp   <= '0;
         r_side   <= 1'b0;
         r_ready  <= 1'b0;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_hc_o   <= '0;
         r_wt_o   <= '0;
         r_side_o <= 1'b0;
         r_perp_o <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_step_x <= w_step_x_nxt;
         r_step_y <= w_step_y_nxt;
         r_sdx    <= w_sdx_nxt;
         r_sdy    <= w_sdy_nxt;
         r_ddx    <= w_ddx_nxt;
         r_ddy    <= w_ddy_nxt;
         r_map_x  <= w_map_x_nxt;
         r_map_y  <= w_map_y_nxt;
         r_hcount <= w_hcount_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wait   <= w_wait_nxt;
         r_perp   <= w_perp_nxt;
         r_side   <= w_side_nxt;
         r_ready  <= w_ready_nxt;
         r_addr   <= w_addr_nxt;
         r_valid  <= w_valid_nxt;
         r_hc_o   <= w_hc_o_nxt;
         r_wt_o   <= w_wt_o_nxt;
         r_side_o <= w_side_o_nxt;
         r_perp_o <= w_perp_o_nxt;
      end
   end

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt  = r_state;
      w_step_x_nxt = r_step_x;
      w_step_y_nxt = r_step_y;
      w_sdx_nxt    = r_sdx;
      w_sdy_nxt    = r_sdy;
      w_ddx_nxt    = r_ddx;
      w_ddy_nxt    = r_ddy;
      w_map_x_nxt  = r_map_x;
      w_map_y_nxt  = r_map_y;
      w_hcount_nxt = r_hcount;
      w_cnt_nxt    = r_cnt;
      w_wait_nxt   = r_wait;
      w_perp_nxt   = r_perp;
      w_side_nxt   = r_side;
      w_ready_nxt  = r_ready;
      w_addr_nxt   = r_addr;
      w_valid_nxt  = r_valid;
      w_hc_o_nxt   = r_hc_o;
      w_wt_o_nxt   = r_wt_o;
      w_side_o_nxt = r_side_o;
      w_perp_o_nxt = r_perp_o;

      case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            if (valid_ray_in && r_ready) begin
               // Latch the ray; start cell is checked before any step
               w_step_x_nxt = stepX_in;
               w_step_y_nxt = stepY_in;
               w_sdx_nxt    = sideDistX_in;
               w_sdy_nxt    = sideDistY_in;
               w_ddx_nxt    = deltaDistX_in;
               w_ddy_nxt    = deltaDistY_in;
               w_map_x_nxt  = posX_in[15:8];
               w_map_y_nxt  = posY_in[15:8];
               w_hcount_nxt = hcount_in;
               w_cnt_nxt    = '0;
               w_wait_nxt   = '0;
               w_perp_nxt   = '0;
               w_side_nxt   = 1'b0;
               w_addr_nxt   = cell_addr(posX_in[15:8], posY_in[15:8]);
               w_ready_nxt  = 1'b0;
               w_state_nxt  = S_FETCH;
            end
         end

         S_FETCH: begin
            // Address is already on the port; wait out the BRAM latency
            if (r_wait == LAT_W'(MAP_LAT - 1)) begin
               w_state_nxt = S_CHECK;
            end else begin
               w_wait_nxt = r_wait + LAT_W'(1);
            end
         end

         S_CHECK: begin
            if (map_data_in != 4'd0) begin
               w_valid_nxt  = 1'b1;
               w_hc_o_nxt   = r_hcount;
               w_wt_o_nxt   = map_data_in;
               w_side_o_nxt = r_side;
               w_perp_o_nxt = r_perp;
               w_state_nxt  = S_DONE;
            end else if (r_cnt == CNT_W'(MAX_STEPS)) begin
               w_valid_nxt  = 1'b1;
               w_hc_o_nxt   = r_hcount;
               w_wt_o_nxt   = 4'd0;
               w_side_o_nxt = r_side;
               w_perp_o_nxt = 16'hFFFF;
               w_state_nxt  = S_DONE;
            end else begin
               w_state_nxt = S_STEP;
            end
         end

         S_STEP: begin
            if (w_take_x) begin
               w_perp_nxt  = r_sdx;
               w_sdx_nxt   = sat_add(r_sdx, r_ddx);
               w_map_x_nxt = w_mx_step;
               w_side_nxt  = 1'b0;
            end else begin
               w_perp_nxt  = r_sdy;
               w_sdy_nxt   = sat_add(r_sdy, r_ddy);
               w_map_y_nxt = w_my_step;
               w_side_nxt  = 1'b1;
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
            // Leaving the map (including wrap below 0) ends the ray as no-hit
            if ((w_nx >= MAP_LIM) || (w_ny >= MAP_LIM)) begin
               w_valid_nxt  = 1'b1;
               w_hc_o_nxt   = r_hcount;
               w_wt_o_nxt   = 4'd0;
               w_side_o_nxt = ~w_take_x;
               w_perp_o_nxt = 16'hFFFF;
               w_state_nxt  = S_DONE;
            end else begin
               w_addr_nxt  = cell_addr(w_nx, w_ny);
               w_wait_nxt  = '0;
               w_state_nxt = S_FETCH;
            end
         end

         S_DONE: begin
            if (ready_in) begin
               w_valid_nxt = 1'b0;
               w_ready_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign dda_data_ready_out = r_ready;
   assign map_addr_out       = r_addr;
   assign valid_out          = r_valid;
   assign hcount_out         = r_hc_o;
   assign wallType_out       = r_wt_o;
   assign wallSide_out       = r_side_o;
   assign perpWallDist_out   = r_perp_o;

endmodule

// File: tb/tb_dda_stepper.sv
// Scoreboard bench for dda_stepper: directed rays with hand-computed results,
// a 2-cycle map BRAM model, backpressure and mid-walk reset.
module tb_dda_stepper;

   localparam int unsigned MAP_SIZE  = 24;
   localparam int unsigned MAP_LAT   = 2;
   localparam int unsigned MAX_STEPS = 4;
   localparam int unsigned ADDR_W    = 10;

   logic              clk = 1'b0;
   logic              rst_in;
   logic              valid_ray_in;
   logic              stepX_in, stepY_in;
   logic [15:0]       sideDistX_in, sideDistY_in, deltaDistX_in, deltaDistY_in;
   logic [15:0]       posX_in, posY_in;
   logic [8:0]        hcount_in;
   logic              dda_data_ready_out;
   logic [ADDR_W-1:0] map_addr_out;
   logic [3:0]        map_data_in;
   logic              ready_in;
   logic              valid_out;
   logic [8:0]        hcount_out;
   logic [3:0]        wallType_out;
   logic              wallSide_out;
   logic [15:0]       perpWallDist_out;

   always #5 clk = ~clk;

   dda_stepper #(
      .MAP_SIZE (MAP_SIZE),
      .MAP_LAT  (MAP_LAT),
      .MAX_STEPS(MAX_STEPS),
      .ADDR_W   (ADDR_W)
   ) dut (
      .pixel_clk_in      (clk),
      .rst_in            (rst_in),
      .valid_ray_in      (valid_ray_in),
      .stepX_in          (stepX_in),
      .stepY_in          (stepY_in),
      .sideDistX_in      (sideDistX_in),
      .sideDistY_in      (sideDistY_in),
      .deltaDistX_in     (deltaDistX_in),
      .deltaDistY_in     (deltaDistY_in),
      .posX_in           (posX_in),
      .posY_in           (posY_in),
      .hcount_in         (hcount_in),
      .dda_data_ready_out(dda_data_ready_out),
      .map_addr_out      (map_addr_out),
      .map_data_in       (map_data_in),
      .ready_in          (ready_in),
      .valid_out         (valid_out),
      .hcount_out        (hcount_out),
      .wallType_out      (wallType_out),
      .wallSide_out      (wallSide_out),
      .perpWallDist_out  (perpWallDist_out)
   );

   // Map BRAM model: two register stages from address to data
   logic [3:0] mem [0:1023];
   logic [3:0] d1, d2;
   always @(posedge clk) begin
      d1 <= mem[map_addr_out];
      d2 <= d1;
   end
   assign map_data_in = d2;

   typedef struct {
      logic [8:0]  hc;
      logic [3:0]  wt;
      logic        side;
      logic [15:0] perp;
      int          stall;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic put_cell(input int x, input int y, input logic [3:0] t);
      mem[y * MAP_SIZE + x] = t;
   endtask

   task automatic send_ray(input logic [15:0] px, input logic [15:0] py,
                           input logic [15:0] sdx, input logic [15:0] sdy,
                           input logic [15:0] ddx, input logic [15:0] ddy,
                           input logic sx, input logic sy, input logic [8:0] hc,
                           input bit push, input logic [3:0] wt, input logic side,
                           input logic [15:0] perp, input int stall);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clk);
      while (!dda_data_ready_out && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!dda_data_ready_out) begin
         check("ready_timeout", 32'(dda_data_ready_out), 32'd1);
         return;
      end
      if (push) begin
         e.hc = hc; e.wt = wt; e.side = side; e.perp = perp; e.stall = stall;
         q.push_back(e);
      end
      posX_in = px; posY_in = py;
      sideDistX_in = sdx; sideDistY_in = sdy;
      deltaDistX_in = ddx; deltaDistY_in = ddy;
      stepX_in = sx; stepY_in = sy; hcount_in = hc;
      valid_ray_in = 1'b1;
      @(posedge clk);
      #1 valid_ray_in = 1'b0;
   endtask

   task automatic drain(input int limit);
      int w;
      w = 0;
      while (q.size() != 0 && w < limit) begin
         @(negedge clk);
         w++;
      end
      check("drain", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   // Monitor: pops the expected result on every presented output
   initial begin : monitor
      exp_t        e;
      logic [29:0] snap;
      ready_in = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_in === 1'b1 && valid_out === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 32'(valid_out), 32'd0);
               @(posedge clk);
            end else begin
               e = q.pop_front();
               if (e.stall > 0) begin
                  ready_in = 1'b0;
                  snap = {hcount_out, wallType_out, wallSide_out, perpWallDist_out};
                  for (int i = 0; i < e.stall; i++) begin
                     @(negedge clk);
                     check("stall_valid", 32'(valid_out), 32'd1);
                     check("stall_fields",
                           32'({hcount_out, wallType_out, wallSide_out, perpWallDist_out}),
                           32'(snap));
                     check("stall_ray_ready", 32'(dda_data_ready_out), 32'd0);
                  end
                  ready_in = 1'b1;
               end
               check("hcount",   32'(hcount_out),       32'(e.hc));
               check("wallType", 32'(wallType_out),     32'(e.wt));
               check("wallSide", 32'(wallSide_out),     32'(e.side));
               check("perpDist", 32'(perpWallDist_out), 32'(e.perp));
               @(posedge clk);
            end
         end
      end
   end

   // Watchdog
   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: run exceeded 20000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
      put_cell(5, 2, 4'd3);    // east ray target
      put_cell(11, 10, 4'd5);  // tie: X neighbour
      put_cell(10, 11, 4'd6);  // tie: Y neighbour (must not be hit)
      put_cell(12, 7, 4'd9);   // just past the step budget
      put_cell(3, 5, 4'd7);    // Y-side hit
      put_cell(9, 17, 4'd4);   // saturation: correct path
      put_cell(10, 16, 4'd8);  // saturation: wrapped-sum path
      put_cell(20, 20, 4'd1);  // start-cell hit

      rst_in = 1'b0; valid_ray_in = 1'b0;
      stepX_in = 1'b0; stepY_in = 1'b0;
      sideDistX_in = '0; sideDistY_in = '0; deltaDistX_in = '0; deltaDistY_in = '0;
      posX_in = '0; posY_in = '0; hcount_in = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid",   32'(valid_out),          32'd0);
      check("rst_ready",   32'(dda_data_ready_out), 32'd0);
      check("rst_addr",    32'(map_addr_out),       32'd0);
      check("rst_hcount",  32'(hcount_out),         32'd0);
      check("rst_type",    32'(wallType_out),       32'd0);
      check("rst_side",    32'(wallSide_out),       32'd0);
      check("rst_perp",    32'(perpWallDist_out),   32'd0);
      rst_in = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(dda_data_ready_out), 32'd1);

      // east ray: 3 X steps to (5,2)
      send_ray(16'h0280, 16'h0280, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1,
               9'd17, 1'b1, 4'd3, 1'b0, 16'h0280, 0);
      // tie steps X first
      send_ray(16'h0A00, 16'h0A00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1,
               9'd100, 1'b1, 4'd5, 1'b0, 16'h0100, 0);
      // exit left through 0-1 = 255
      send_ray(16'h0080, 16'h0580, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, 1'b1,
               9'd0, 1'b1, 4'd0, 1'b0, 16'hFFFF, 0);
      // step budget of 4 Y steps, wall one step beyond
      send_ray(16'h0C80, 16'h0C80, 16'hFFFF, 16'h0040, 16'hFFFF, 16'h0100, 1'b1, 1'b0,
               9'd319, 1'b1, 4'd0, 1'b1, 16'hFFFF, 0);
      // two Y steps to a Y-side hit
      send_ray(16'h0380, 16'h0380, 16'h0200, 16'h0040, 16'h0100, 16'h0100, 1'b1, 1'b1,
               9'd200, 1'b1, 4'd7, 1'b1, 16'h0140, 0);
      // sideDistX saturates, so the second step goes along Y
      send_ray(16'h0800, 16'h1000, 16'hFF00, 16'hFF80, 16'h0200, 16'h0010, 1'b1, 1'b1,
               9'd300, 1'b1, 4'd4, 1'b1, 16'hFF80, 0);
      // wall in the start cell
      send_ray(16'h1400, 16'h1400, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1,
               9'd511, 1'b1, 4'd1, 1'b0, 16'h0000, 0);
      // backpressure: downstream stalls 10 cycles
      send_ray(16'h0280, 16'h0280, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1,
               9'd42, 1'b1, 4'd3, 1'b0, 16'h0280, 10);
      drain(1000);

      // reset mid-walk: ray is dropped silently
      send_ray(16'h0280, 16'h0280, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1,
               9'd77, 1'b0, 4'd0, 1'b0, 16'h0000, 0);
      repeat (5) @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(valid_out),          32'd0);
      check("midrst_ready", 32'(dda_data_ready_out), 32'd0);
      check("midrst_addr",  32'(map_addr_out),       32'd0);
      rst_in = 1'b1;
      @(negedge clk);
      check("midrst_ready_up", 32'(dda_data_ready_out), 32'd1);
      repeat (30) @(negedge clk);
      send_ray(16'h0A00, 16'h0A00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1,
               9'd5, 1'b1, 4'd5, 1'b0, 16'h0100, 0);
      drain(1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
